// File: rtl/pio_sched_pkg.sv
// Shared types and constants for the PIO edge-capture event scheduler.
package pio_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_EVENT    = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_CTRL     = 2'd2;
    localparam logic [1:0] PIO_EDGE_ADDR = 2'd3;

    // A queued event is {source index, edge mask}.
    function automatic int entry_w(input int src_w, input int data_w);
        return src_w + data_w;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO; a pop on empty is ignored, push+pop at full both land.
module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pio_event_scheduler.sv
// Round-robin service of PIO edge-capture interrupts into an event FIFO,
// drained by the CPU through a small register slave.
module pio_event_scheduler
    import pio_sched_pkg::*;
#(
    parameter int N_SRC  = 2,
    parameter int DATA_W = 18,
    parameter int DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_SRC-1:0]     irq_in,
    output logic [N_SRC-1:0]     m_chipselect,
    output logic [1:0]           m_address,
    output logic                 m_write_n,
    output logic [31:0]          m_writedata,
    input  logic [N_SRC*32-1:0]  m_readdata,
    input  logic                 s_chipselect,
    input  logic [1:0]           s_address,
    input  logic                 s_read_n,
    input  logic                 s_write_n,
    input  logic [31:0]          s_writedata,
    output logic [31:0]          s_readdata,
    output logic                 irq
);
    localparam int SRC_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int ENTRY_W = entry_w(SRC_W, DATA_W);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    state_t             state_reg, state_next;
    logic [SRC_W-1:0]   grant_reg, grant_next;
    logic [SRC_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [N_SRC-1:0]   skip_reg, skip_next;
    logic [N_SRC-1:0]   cs_reg, cs_next;
    logic [1:0]         addr_reg, addr_next;
    logic               wr_n_reg, wr_n_next;
    logic               enable_reg, irq_en_reg;
    logic [31:0]        s_readdata_reg;

    logic [N_SRC-1:0]   req;
    logic [DATA_W-1:0]  rd_slice [N_SRC];
    logic [N_SRC*(32-DATA_W)-1:0] rd_unused;
    logic               unused_bits;
    logic               push, pop, full, empty, s_read;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   fifo_count;
    logic [31:0]        ev_word, rd_word;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_slice
            assign rd_slice[gi] = m_readdata[32*gi +: DATA_W];
            assign rd_unused[(32-DATA_W)*gi +: (32-DATA_W)] = m_readdata[32*gi+DATA_W +: (32-DATA_W)];
        end
    endgenerate
    assign unused_bits = ^{rd_unused, s_writedata[31:2]};

    // Lowest requesting index at or after ptr, wrapping.
    function automatic logic [SRC_W-1:0] rr_pick(input logic [N_SRC-1:0] r,
                                                 input logic [SRC_W-1:0] ptr);
        logic [SRC_W-1:0] pick;
        logic [SRC_W-1:0] idx;
        pick = ptr;
        for (int off = N_SRC - 1; off >= 0; off--) begin
            idx = SRC_W'((int'(ptr) + off) % N_SRC);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    // The PIO irq can read stale-high right after its clear.
    assign req = irq_in & ~skip_reg;

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        skip_next   = '0;
        cs_next     = '0;
        addr_next   = addr_reg;
        wr_n_next   = 1'b1;
        push        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable_reg && !full && (|req)) begin
                    grant_next          = rr_pick(req, rr_ptr_reg);
                    cs_next[grant_next] = 1'b1;
                    addr_next           = PIO_EDGE_ADDR;
                    state_next          = READ;
                end
            end
            READ: state_next = CAPTURE;
            CAPTURE: begin
                push               = |rd_slice[grant_reg];
                cs_next[grant_reg] = 1'b1;
                addr_next          = PIO_EDGE_ADDR;
                wr_n_next          = 1'b0;
                state_next         = CLEAR;
            end
            CLEAR: begin
                rr_ptr_next = (grant_reg == SRC_W'(N_SRC - 1)) ? '0 : grant_reg + 1'b1;
                skip_next[grant_reg] = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
            skip_reg   <= '0;
            cs_reg     <= '0;
            addr_reg   <= '0;
            wr_n_reg   <= 1'b1;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
            skip_reg   <= skip_next;
            cs_reg     <= cs_next;
            addr_reg   <= addr_next;
            wr_n_reg   <= wr_n_next;
        end
    end

    event_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     ({grant_reg, rd_slice[grant_reg]}),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign s_read = s_chipselect & ~s_read_n;
    assign pop    = s_read & (s_address == ADDR_EVENT) & ~empty;

    always_comb begin
        ev_word = '0;
        if (!empty) begin
            ev_word[31]            = 1'b1;
            ev_word[24 +: SRC_W]   = head[DATA_W +: SRC_W];
            ev_word[DATA_W-1:0]    = head[DATA_W-1:0];
        end
    end

    always_comb begin
        rd_word = '0;
        case (s_address)
            ADDR_EVENT:  rd_word = ev_word;
            ADDR_STATUS: rd_word[7:0] = 8'(fifo_count);
            ADDR_CTRL:   rd_word[1:0] = {irq_en_reg, enable_reg};
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_readdata_reg <= '0;
            enable_reg     <= 1'b0;
            irq_en_reg     <= 1'b0;
        end else begin
            if (s_read) s_readdata_reg <= rd_word;
            if (s_chipselect && !s_write_n && (s_address == ADDR_CTRL)) begin
                enable_reg <= s_writedata[0];
                irq_en_reg <= s_writedata[1];
            end
        end
    end

    assign m_chipselect = cs_reg;
    assign m_address    = addr_reg;
    assign m_write_n    = wr_n_reg;
    assign m_writedata  = '0;
    assign s_readdata   = s_readdata_reg;
    assign irq          = irq_en_reg & (fifo_count != '0);

endmodule

// File: tb/tb_pio_event_scheduler.sv
// Directed bench for pio_event_scheduler with PIO models and an event scoreboard.
module tb_pio_event_scheduler;
    localparam int N_SRC  = 2;
    localparam int DATA_W = 18;
    localparam int DEPTH  = 8;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [N_SRC-1:0]    irq_in;
    logic [N_SRC-1:0]    m_chipselect;
    logic [1:0]          m_address;
    logic                m_write_n;
    logic [31:0]         m_writedata;
    logic [N_SRC*32-1:0] m_readdata;
    logic                s_chipselect = 1'b0;
    logic [1:0]          s_address = 2'd0;
    logic                s_read_n = 1'b1;
    logic                s_write_n = 1'b1;
    logic [31:0]         s_writedata = 32'd0;
    logic [31:0]         s_readdata;
    logic                irq;

    logic [DATA_W-1:0] cap [N_SRC] = '{default: '0};
    logic [DATA_W-1:0] inj [N_SRC] = '{default: '0};
    logic [31:0]       pio_rd [N_SRC] = '{default: '0};
    logic [N_SRC-1:0]  pio_irq = '0;
    logic [N_SRC-1:0]  spur = '0;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    pio_event_scheduler #(.N_SRC(N_SRC), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .irq_in       (irq_in),
        .m_chipselect (m_chipselect),
        .m_address    (m_address),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .s_chipselect (s_chipselect),
        .s_address    (s_address),
        .s_read_n     (s_read_n),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .irq          (irq)
    );

    // PIO models: edge capture, clear on write, registered readdata and irq.
    always @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (m_chipselect[i] && m_address == 2'd3 && !m_write_n) cap[i] <= inj[i];
            else cap[i] <= cap[i] | inj[i];
            if (m_chipselect[i] && m_address == 2'd3 && m_write_n) pio_rd[i] <= {14'h2aaa, cap[i]};
            pio_irq[i] <= |cap[i];
        end
    end

    assign irq_in = pio_irq | spur;
    always_comb begin
        m_readdata = '0;
        for (int i = 0; i < N_SRC; i++) m_readdata[32*i +: 32] = pio_rd[i];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
        $display("check %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_word(input int src, input logic [DATA_W-1:0] m);
        return 32'h8000_0000 | (32'(src) << 24) | 32'(m);
    endfunction

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        s_chipselect = 1'b1; s_address = a; s_write_n = 1'b0; s_writedata = d;
        tick();
        s_chipselect = 1'b0; s_write_n = 1'b1; s_writedata = 32'd0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        s_chipselect = 1'b1; s_address = a; s_read_n = 1'b0;
        tick();
        s_chipselect = 1'b0; s_read_n = 1'b1;
        d = s_readdata;
    endtask

    task automatic pop_event(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        cpu_read(2'd0, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'd0;
        check(tag, d, e);
    endtask

    task automatic status_check(input string tag, input logic [31:0] e);
        logic [31:0] d;
        cpu_read(2'd1, d);
        check(tag, d, e);
    endtask

    task automatic inject(input int src, input logic [DATA_W-1:0] m);
        inj[src] = m;
        tick();
        inj[src] = '0;
    endtask

    task automatic wait_read(input int src, input int max, input string tag);
        int n = 0;
        while (!(m_chipselect[src] && m_write_n) && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(m_chipselect[src] && m_write_n), 32'd1);
    endtask

    task automatic count_busy(input int cycles, output int busy);
        busy = 0;
        repeat (cycles) begin
            tick();
            if (|m_chipselect) busy++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int busy;
        int seen;

        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("rst_cs", 32'(m_chipselect), 32'd0);
        check("rst_addr", 32'(m_address), 32'd0);
        check("rst_write_n", 32'(m_write_n), 32'd1);
        check("rst_writedata", m_writedata, 32'd0);
        check("rst_readdata", s_readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        cpu_read(2'd2, d);
        check("rst_ctrl", d, 32'd0);
        cpu_write(2'd2, 32'd3);

        // Single event with exact cycle-level latency.
        inject(1, 18'h5);
        exp_q.push_back(exp_word(1, 18'h5));
        tick();
        check("t1_no_early_cs", 32'(m_chipselect), 32'd0);
        tick();
        check("t1_read_cs", 32'(m_chipselect), 32'd2);
        check("t1_read_addr", 32'(m_address), 32'd3);
        check("t1_read_write_n", 32'(m_write_n), 32'd1);
        tick();
        check("t1_capture_cs", 32'(m_chipselect), 32'd0);
        check("t1_capture_irq", 32'(irq), 32'd0);
        tick();
        check("t1_clear_cs", 32'(m_chipselect), 32'd2);
        check("t1_clear_addr", 32'(m_address), 32'd3);
        check("t1_clear_write_n", 32'(m_write_n), 32'd0);
        check("t1_clear_wdata", m_writedata, 32'd0);
        check("t1_irq_after_push", 32'(irq), 32'd1);
        tick();
        check("t1_idle_cs", 32'(m_chipselect), 32'd0);
        tick();
        check("t1_stale_irq_ignored", 32'(m_chipselect), 32'd0);
        pop_event("t1_event");
        check("t1_irq_after_pop", 32'(irq), 32'd0);

        // Both pending from rr_ptr 0, twice.
        for (int r = 0; r < 2; r++) begin
            inj[0] = (r == 0) ? 18'h00011 : 18'h0f0f0;
            inj[1] = (r == 0) ? 18'h20000 : 18'h00001;
            exp_q.push_back(exp_word(0, inj[0]));
            exp_q.push_back(exp_word(1, inj[1]));
            tick();
            inj[0] = '0; inj[1] = '0;
            repeat (12) tick();
            status_check("t2_count2", 32'd2);
            pop_event("t2_first");
            pop_event("t2_second");
        end

        // Serve PIO0 alone so the pointer moves to 1, then both: order 1,0.
        inject(0, 18'h40);
        exp_q.push_back(exp_word(0, 18'h40));
        repeat (7) tick();
        inj[0] = 18'h41; inj[1] = 18'h42;
        exp_q.push_back(exp_word(1, 18'h42));
        exp_q.push_back(exp_word(0, 18'h41));
        tick();
        inj[0] = '0; inj[1] = '0;
        repeat (12) tick();
        pop_event("t2c_alone");
        pop_event("t2c_rr_first");
        pop_event("t2c_rr_second");

        // Fill the FIFO and check back-pressure.
        for (int k = 0; k < DEPTH; k++) begin
            inject(k % 2, DATA_W'(18'h100 + k));
            exp_q.push_back(exp_word(k % 2, DATA_W'(18'h100 + k)));
            repeat (7) tick();
        end
        status_check("t3_full_count", 32'd8);
        inject(1, 18'h30003);
        exp_q.push_back(exp_word(1, 18'h30003));
        count_busy(20, busy);
        check("t3_no_cs_when_full", 32'(busy), 32'd0);
        check("t3_irq_in_held", 32'(irq_in[1]), 32'd1);
        cpu_write(2'd2, 32'd1);
        check("t3_irq_masked", 32'(irq), 32'd0);
        cpu_write(2'd2, 32'd3);
        pop_event("t3_pop_first");
        wait_read(1, 3, "t3_resume_after_pop");
        repeat (6) tick();
        status_check("t3_refilled", 32'd8);
        for (int k = 0; k < DEPTH; k++) pop_event("t3_drain");
        pop_event("t3_empty_read");
        status_check("t3_count0", 32'd0);

        // Spurious irq with empty edge capture.
        spur[0] = 1'b1;
        tick();
        spur[0] = 1'b0;
        seen = 0;
        for (int n = 0; n < 6 && seen == 0; n++) begin
            if (m_chipselect[0] && !m_write_n) seen = 1;
            else tick();
        end
        check("t4_spurious_clear", 32'(seen), 32'd1);
        repeat (3) tick();
        status_check("t4_no_push", 32'd0);
        check("t4_irq_low", 32'(irq), 32'd0);

        // Disable during READ: sequence completes, no further grants.
        inject(1, 18'h0abc);
        exp_q.push_back(exp_word(1, 18'h0abc));
        wait_read(1, 4, "t5_read");
        cpu_write(2'd2, 32'd2);
        repeat (4) tick();
        inject(0, 18'h7);
        count_busy(10, busy);
        check("t5_no_grant_disabled", 32'(busy), 32'd0);
        status_check("t5_pushed", 32'd1);
        check("t5_pio0_pending", 32'(irq_in[0]), 32'd1);

        // Reset while in CAPTURE.
        cpu_write(2'd2, 32'd3);
        wait_read(0, 4, "t6_read");
        tick();
        reset_n = 1'b0;
        #1;
        check("t6_rst_cs", 32'(m_chipselect), 32'd0);
        check("t6_rst_addr", 32'(m_address), 32'd0);
        check("t6_rst_write_n", 32'(m_write_n), 32'd1);
        check("t6_rst_readdata", s_readdata, 32'd0);
        check("t6_rst_irq", 32'(irq), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        exp_q.delete();
        tick();
        status_check("t6_fifo_empty", 32'd0);
        check("t6_still_pending", 32'(irq_in[0]), 32'd1);
        cpu_write(2'd2, 32'd3);
        exp_q.push_back(exp_word(0, 18'h7));
        wait_read(0, 4, "t6_resume");
        repeat (5) tick();
        pop_event("t6_event");
        pop_event("t6_empty");
        cpu_read(2'd3, d);
        check("reserved_reads_0", d, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
